// File: rtl/fifo_stream_pkg.sv
// Shared constants and helpers for the FIFO stream reader: buffer depth, occupancy type
// and the read-latency legality check used at elaboration.
package fifo_stream_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] cnt_t;

  function automatic bit legal_latency(input int lat);
    return (lat == 0) || (lat == 1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bus bundle between the FIFO read port, the stream reader and the stream sink.
// master = the reader (drives fifo_rd_en and the m_* stream); slave = FIFO/sink side.
interface fifo_stream_reader_if #(
  parameter int WIDTH_DATA = 8
);

  // Handshake: a stream word transfers on every posedge where m_valid && m_ready.
  // m_valid never depends on m_ready; while m_valid && !m_ready, m_data/m_last hold.
  // fifo_rd_en is only raised when fifo_empty is low; data follows RD_LATENCY cycles later.
  logic                  fifo_rd_en;
  logic [WIDTH_DATA-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [WIDTH_DATA-1:0] m_data;
  logic                  m_last;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );

endinterface

// File: rtl/fifo_stream_skid.sv
// Two-entry register buffer: push appends at the tail, pop removes the head; both may
// happen in the same cycle. head_data is always entry 0.
module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH_DATA = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH_DATA-1:0] push_data,
  input  logic                  pop,
  output cnt_t                  cnt,
  output logic [WIDTH_DATA-1:0] head_data
);

  logic [WIDTH_DATA-1:0] d0;
  logic [WIDTH_DATA-1:0] d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      d0  <= '0;
      d1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) d0 <= push_data;
          else             d1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the head advances and the new word lands behind it.
          if (cnt == 2'd1) begin
            d0 <= push_data;
          end else begin
            d0 <= d1;
            d1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = d0;

  no_overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (cnt == cnt_t'(BUF_DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port into a valid/ready stream through a 2-entry buffer.
// Optional packet marking on m_last is enabled by defining STREAM_LAST_EN.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH_DATA = 8,
  parameter int RD_LATENCY = 0,
  parameter int PKT_LEN    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
);

  if (!legal_latency(RD_LATENCY)) begin : g_bad_latency
    $error("fifo_stream_reader: RD_LATENCY must be 0 or 1");
  end
  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("fifo_stream_reader: PKT_LEN must be >= 1");
  end

  cnt_t                  cnt;
  logic                  inflt;
  logic                  push;
  logic                  pop;
  logic                  rd_en;
  logic                  m_valid;
  logic                  m_last;
  logic [WIDTH_DATA-1:0] head_data;
  logic [2:0]            room_need;

  assign m_valid = !rst && (cnt != 2'd0);
  assign pop     = m_valid && bus.m_ready;

  // Slots already promised (held + in flight) after this cycle's pop must leave room.
  assign room_need = {1'b0, cnt} + {2'b00, inflt} - {2'b00, pop};
  assign rd_en     = !rst && !bus.fifo_empty && (room_need < 3'd2);

  if (RD_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) inflt <= 1'b0;
      else     inflt <= rd_en;
    end
    assign push = inflt;
  end else begin : g_lat0
    assign inflt = 1'b0;
    assign push  = rd_en;
  end

  fifo_stream_skid #(
    .WIDTH_DATA(WIDTH_DATA)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.fifo_rd_data),
    .pop       (pop),
    .cnt       (cnt),
    .head_data (head_data)
  );

`ifdef STREAM_LAST_EN
  localparam int WCNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  logic [WCNT_W-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (pop) begin
      if (wcnt == WCNT_W'(PKT_LEN - 1)) wcnt <= '0;
      else                              wcnt <= wcnt + WCNT_W'(1);
    end
  end

  assign m_last = m_valid && (wcnt == WCNT_W'(PKT_LEN - 1));
`else
  assign m_last = 1'b0;
`endif

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = rst ? '0 : head_data;
  assign bus.m_last     = m_last;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: lane 0 uses RD_LATENCY=0, lane 1 RD_LATENCY=1, each fed
// by its own 8-deep FIFO model driven with the same writes and the same m_ready.
module tb_fifo_stream_reader;

  localparam int W       = 8;
  localparam int DEPTH   = 8;
  localparam int PKT_LEN = 3;
  localparam int NL      = 2;
`ifdef STREAM_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  wr_en   = 1'b0;
  logic [W-1:0]          wr_data = '0;
  logic                  m_ready = 1'b0;
  logic [NL-1:0]         rd_en;
  logic [NL-1:0]         empty;
  logic [NL-1:0]         m_valid;
  logic [NL-1:0]         m_last;
  logic [NL-1:0][W-1:0]  rd_data;
  logic [NL-1:0][W-1:0]  m_data;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- DUTs ----------------
  fifo_stream_reader_if #(.WIDTH_DATA(W)) if0 ();
  fifo_stream_reader_if #(.WIDTH_DATA(W)) if1 ();

  fifo_stream_reader #(.WIDTH_DATA(W), .RD_LATENCY(0), .PKT_LEN(PKT_LEN)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  fifo_stream_reader #(.WIDTH_DATA(W), .RD_LATENCY(1), .PKT_LEN(PKT_LEN)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  assign if0.fifo_rd_data = rd_data[0];
  assign if0.fifo_empty   = empty[0];
  assign if0.m_ready      = m_ready;
  assign rd_en[0]         = if0.fifo_rd_en;
  assign m_valid[0]       = if0.m_valid;
  assign m_data[0]        = if0.m_data;
  assign m_last[0]        = if0.m_last;

  assign if1.fifo_rd_data = rd_data[1];
  assign if1.fifo_empty   = empty[1];
  assign if1.m_ready      = m_ready;
  assign rd_en[1]         = if1.fifo_rd_en;
  assign m_valid[1]       = if1.m_valid;
  assign m_data[1]        = if1.m_data;
  assign m_last[1]        = if1.m_last;

  // ---------------- FIFO models ----------------
  logic [W-1:0] mem   [NL][DEPTH];
  logic [2:0]   wp    [NL];
  logic [2:0]   rp    [NL];
  logic [3:0]   usedw [NL];
  logic [W-1:0] rd_q  [NL];

  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (rst) begin
        wp[l]    <= '0;
        rp[l]    <= '0;
        usedw[l] <= '0;
        rd_q[l]  <= '0;
      end else begin
        if (wr_en) begin
          mem[l][wp[l]] <= wr_data;
          wp[l]         <= wp[l] + 3'd1;
        end
        if (rd_en[l]) begin
          rp[l]   <= rp[l] + 3'd1;
          rd_q[l] <= mem[l][rp[l]];
        end
        usedw[l] <= usedw[l] + 4'(wr_en) - 4'(rd_en[l]);
      end
    end
  end

  assign empty[0]   = (usedw[0] == 4'd0);
  assign empty[1]   = (usedw[1] == 4'd0);
  assign rd_data[0] = mem[0][rp[0]];
  assign rd_data[1] = rd_q[1];

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int lane, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h at %0t", name, lane, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int           rd_idx [NL];
  int           wcnt_m [NL];
  int           nlast  [NL];
  logic         stall_p[NL];
  logic [W-1:0] stall_d[NL];
  logic         stall_l[NL];

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (rst) begin
        rd_idx[l]  = exp_q.size();
        wcnt_m[l]  = 0;
        stall_p[l] = 1'b0;
      end else begin
        if (rd_en[l]) chk("rd_en_while_empty", l, int'(empty[l]), 0);
        if (stall_p[l]) begin
          chk("stall_valid", l, int'(m_valid[l]), 1);
          chk("stall_data", l, int'(m_data[l]), int'(stall_d[l]));
          chk("stall_last", l, int'(m_last[l]), int'(stall_l[l]));
        end
        if (m_valid[l] && m_ready) begin
          if (rd_idx[l] < exp_q.size()) begin
            chk("data_order", l, int'(m_data[l]), int'(exp_q[rd_idx[l]]));
          end else begin
            chk("extra_word", l, int'(m_data[l]) + 256, -1);
          end
          chk("last_flag", l, int'(m_last[l]), int'(LAST_EN && (wcnt_m[l] == PKT_LEN - 1)));
          if (m_last[l]) nlast[l]++;
          rd_idx[l]++;
          wcnt_m[l] = (wcnt_m[l] == PKT_LEN - 1) ? 0 : wcnt_m[l] + 1;
        end
        stall_p[l] = m_valid[l] && !m_ready;
        stall_d[l] = m_data[l];
        stall_l[l] = m_last[l];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    int n = 0;
    while ((usedw[0] >= 4'(DEPTH) || usedw[1] >= 4'(DEPTH)) && n < 200) begin
      wr_en = 1'b0;
      tick();
      n++;
    end
    chk("fifo_room_timeout", -1, int'(n >= 200), 0);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    m_ready = 1'b1;
    while ((rd_idx[0] < exp_q.size() || rd_idx[1] < exp_q.size()) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", -1, int'(n >= budget), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int t_e[NL], t_v[NL], t_lv[NL], nv[NL], nrd[NL], nl0[NL];
  int written;

  initial begin
    for (int l = 0; l < NL; l++) begin
      nlast[l] = 0; rd_idx[l] = 0; wcnt_m[l] = 0; stall_p[l] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) tick();
    for (int l = 0; l < NL; l++) begin
      chk("reset_valid", l, int'(m_valid[l]), 0);
      chk("reset_data", l, int'(m_data[l]), 0);
      chk("reset_last", l, int'(m_last[l]), 0);
      chk("reset_rd_en", l, int'(rd_en[l]), 0);
    end
    rst = 1'b0;
    tick();

    // 1: back-to-back 0x01..0x08, m_ready high; latency and 1 word/cycle.
    m_ready = 1'b1;
    for (int l = 0; l < NL; l++) begin
      t_e[l] = -1; t_v[l] = -1; t_lv[l] = -1; nv[l] = 0;
    end
    fork
      begin
        for (int i = 1; i <= 8; i++) push_word(W'(i));
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          for (int l = 0; l < NL; l++) begin
            if (t_e[l] < 0 && !empty[l]) t_e[l] = c;
            if (m_valid[l]) begin
              if (t_v[l] < 0) t_v[l] = c;
              t_lv[l] = c;
              nv[l]++;
            end
          end
        end
      end
    join
    for (int l = 0; l < NL; l++) begin
      chk("t1_first_latency", l, t_v[l] - t_e[l], 1 + l);
      chk("t1_valid_cycles", l, nv[l], 8);
      chk("t1_burst_span", l, t_lv[l] - t_v[l], 7);
    end
    drain(100);

    // 2: 8 words queued with the sink stalled for 10 cycles.
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    repeat (10) tick();
    for (int l = 0; l < NL; l++) begin
      chk("t2_valid", l, int'(m_valid[l]), 1);
      chk("t2_head", l, int'(m_data[l]), 8'h01);
      chk("t2_usedw", l, int'(usedw[l]), 6);
    end
    drain(100);

    // 3: random sink readiness and random write gaps, 1000 words.
    written = 0;
    for (int c = 0; c < 20000 && written < 1000; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && usedw[0] < 4'(DEPTH) && usedw[1] < 4'(DEPTH)) begin
        wr_en   = 1'b1;
        wr_data = W'(written * 7 + 3);
        exp_q.push_back(wr_data);
        written++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    chk("t3_words_written", -1, written, 1000);
    drain(300);

    // 4: fresh reset so the packet count starts at word 1; 7 words.
    do_reset();
    for (int l = 0; l < NL; l++) nl0[l] = nlast[l];
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) push_word(W'(8'h31 + i));
    drain(100);
    for (int l = 0; l < NL; l++) chk("t4_last_count", l, nlast[l] - nl0[l], LAST_EN ? 2 : 0);

    // 5: reset while words are buffered and lane 1 has a read in flight.
    m_ready = 1'b0;
    push_word(8'hC1);
    push_word(8'hC2);
    push_word(8'hC3);
    chk("t5_pre_valid", -1, int'(m_valid), 3);
    chk("t5_pre_inflight", 1, int'(dut1.inflt), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int l = 0; l < NL; l++) begin
      chk("t5_valid_after_rst", l, int'(m_valid[l]), 0);
      chk("t5_data_after_rst", l, int'(m_data[l]), 0);
      chk("t5_last_after_rst", l, int'(m_last[l]), 0);
    end
    push_word(8'hA5);
    drain(100);

    // 6: single word into an idle block with the sink ready.
    m_ready = 1'b1;
    for (int l = 0; l < NL; l++) begin
      nrd[l] = 0; nv[l] = 0;
    end
    fork
      push_word(8'h5A);
      begin
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          for (int l = 0; l < NL; l++) begin
            if (rd_en[l])   nrd[l]++;
            if (m_valid[l]) nv[l]++;
          end
        end
      end
    join
    for (int l = 0; l < NL; l++) begin
      chk("t6_pops", l, nrd[l], 1);
      chk("t6_valid_cycles", l, nv[l], 1);
      chk("t6_rd_en_idle", l, int'(rd_en[l]), 0);
    end
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
